cpu_exec_unit: RTL and testbench

//  Execute stage of the basic 16-bit CPU: sits downstream of control_unit, consumes its
//  one-hot op strobes and execute handshake, owns AC/E, performs indirect-address and

---
 rtl/cpu_pkg.sv | 67 ++++++
 rtl/cpu_exec_alu.sv | 47 ++++
 rtl/cpu_exec_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_exec_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, execute-stage state encoding and op-select decode for the CPU execute unit.
package cpu_pkg;

    localparam int unsigned CPU_DWIDTH = 16;
    localparam int unsigned CPU_AWIDTH = 12;
    localparam int unsigned CPU_IMM_W  = 8;
    localparam int unsigned CPU_NSTRB  = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IND_RD,
        ST_OP_RD,
        ST_OP_WR,
        ST_REG_EX,
        ST_DONE
    } exec_state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH,
        OP_ISZ,
        OP_CLR_AC,
        OP_CLR_E,
        OP_COMP_AC,
        OP_LOAD_AC,
        OP_CIR_R,
        OP_CIR_L,
        OP_INC_AC,
        OP_NONE
    } op_sel_t;

    // Strobe vector is {add,load,store,branch,isz,clr_ac,clr_e,comp_ac,load_ac,cir_r,cir_l,inc_ac}
    function automatic op_sel_t sel_op(input logic [CPU_NSTRB-1:0] strb);
        op_sel_t op;
        if      (strb[11]) op = OP_ADD;
        else if (strb[10]) op = OP_LOAD;
        else if (strb[9])  op = OP_STORE;
        else if (strb[8])  op = OP_BRANCH;
        else if (strb[7])  op = OP_ISZ;
        else if (strb[6])  op = OP_CLR_AC;
        else if (strb[5])  op = OP_CLR_E;
        else if (strb[4])  op = OP_COMP_AC;
        else if (strb[3])  op = OP_LOAD_AC;
        else if (strb[2])  op = OP_CIR_R;
        else if (strb[1])  op = OP_CIR_L;
        else if (strb[0])  op = OP_INC_AC;
        else               op = OP_NONE;
        return op;
    endfunction

    function automatic logic is_mem_op(input op_sel_t op);
        return (op == OP_ADD) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_ISZ);
    endfunction

    // First state once the effective address is known.
    function automatic exec_state_t mem_first_state(input op_sel_t op);
        exec_state_t st;
        if      (op == OP_BRANCH) st = ST_DONE;
        else if (op == OP_STORE)  st = ST_OP_WR;
        else                      st = ST_OP_RD;
        return st;
    endfunction

endpackage

// File: rtl/cpu_exec_alu.sv
// Combinational AC/E datapath: computes the new AC, E and zero flag for the selected op.
module cpu_exec_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DWIDTH = CPU_DWIDTH
) (
    input  op_sel_t               i_op,
    input  logic [DWIDTH-1:0]     i_ac,
    input  logic                  i_e,
    input  logic [DWIDTH-1:0]     i_operand,
    input  logic [CPU_IMM_W-1:0]  i_imm,
    output logic [DWIDTH-1:0]     o_ac_c,
    output logic                  o_e_c,
    output logic                  o_zero_c
);

    logic [DWIDTH:0] w_sum;

    assign w_sum = {1'b0, i_ac} + {1'b0, i_operand};

    always_comb begin
        o_ac_c = i_ac;
        o_e_c  = i_e;
        case (i_op)
            OP_ADD:     {o_e_c, o_ac_c} = w_sum;
            OP_LOAD:    o_ac_c = i_operand;
            // ISZ result goes to the temp register, not AC; top picks it up from o_ac_c
            OP_ISZ:     o_ac_c = i_operand + DWIDTH'(1);
            OP_CLR_AC:  o_ac_c = '0;
            OP_CLR_E:   o_e_c  = 1'b0;
            OP_COMP_AC: o_ac_c = ~i_ac;
            OP_LOAD_AC: o_ac_c = DWIDTH'(i_imm);
            OP_CIR_R: begin
                o_ac_c = {i_e, i_ac[DWIDTH-1:1]};
                o_e_c  = i_ac[0];
            end
            OP_CIR_L: begin
                o_ac_c = {i_ac[DWIDTH-2:0], i_e};
                o_e_c  = i_ac[DWIDTH-1];
            end
            OP_INC_AC:  o_ac_c = i_ac + DWIDTH'(1);
            default: ;
        endcase
        o_zero_c = (o_ac_c == '0);
    end

endmodule

// File: rtl/cpu_exec_unit.sv
// Execute stage: owns AC/E, runs indirect/operand memory accesses and signals PC load/skip and done.
module cpu_exec_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DWIDTH = CPU_DWIDTH,
    parameter int unsigned AWIDTH = CPU_AWIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_execute,
    input  logic                  i_is_ind,
    input  logic [AWIDTH-1:0]     i_addr,
    input  logic [CPU_IMM_W-1:0]  i_imm,
    input  logic                  i_add,
    input  logic                  i_load,
    input  logic                  i_store,
    input  logic                  i_branch,
    input  logic                  i_isz,
    input  logic                  i_clr_ac,
    input  logic                  i_clr_e,
    input  logic                  i_comp_ac,
    input  logic                  i_load_ac,
    input  logic                  i_cir_r,
    input  logic                  i_cir_l,
    input  logic                  i_inc_ac,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [AWIDTH-1:0]     o_mem_addr,
    output logic [DWIDTH-1:0]     o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DWIDTH-1:0]     i_mem_rdata,
    output logic [DWIDTH-1:0]     o_ac,
    output logic                  o_e,
    output logic                  o_pc_load,
    output logic [AWIDTH-1:0]     o_pc_value,
    output logic                  o_pc_skip,
    output logic                  o_busy,
    output logic                  o_ex_done
);

    exec_state_t              r_state, w_nxt_state;
    op_sel_t                  r_op, w_nxt_op, w_start_op;
    logic                     r_exec_d;
    logic [AWIDTH-1:0]        r_addr, w_nxt_addr;
    logic [CPU_IMM_W-1:0]     r_imm, w_nxt_imm;
    logic [AWIDTH-1:0]        r_ea, w_nxt_ea;
    logic [DWIDTH-1:0]        r_opnd, w_nxt_opnd;
    logic [DWIDTH-1:0]        r_tmp, w_nxt_tmp;
    logic                     r_skip, w_nxt_skip;
    logic [DWIDTH-1:0]        r_ac, w_nxt_ac;
    logic                     r_e, w_nxt_e;
    logic                     r_mem_req, w_nxt_req;
    logic                     r_mem_we, w_nxt_we;
    logic [AWIDTH-1:0]        r_mem_addr, w_nxt_maddr;
    logic [DWIDTH-1:0]        r_mem_wdata, w_nxt_wdata;
    logic                     r_pc_load, w_nxt_pc_load;
    logic                     r_pc_skip, w_nxt_pc_skip;
    logic                     r_busy, w_nxt_busy;
    logic                     r_ex_done, w_nxt_ex_done;
    logic                     w_start, w_acc;
    logic [CPU_NSTRB-1:0]     w_strb;
    logic [DWIDTH-1:0]        w_alu_ac;
    logic                     w_alu_e, w_alu_zero;

    assign w_strb = {i_add, i_load, i_store, i_branch, i_isz, i_clr_ac, i_clr_e,
                     i_comp_ac, i_load_ac, i_cir_r, i_cir_l, i_inc_ac};
    assign w_start_op = sel_op(w_strb);
    assign w_start    = i_execute & ~r_exec_d;
    // An ack only counts while our request is actually up
    assign w_acc      = r_mem_req & i_mem_ack;

    cpu_exec_alu #(.DWIDTH(DWIDTH)) u_alu (
        .i_op      (r_op),
        .i_ac      (r_ac),
        .i_e       (r_e),
        .i_operand (r_opnd),
        .i_imm     (r_imm),
        .o_ac_c    (w_alu_ac),
        .o_e_c     (w_alu_e),
        .o_zero_c  (w_alu_zero)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_op    = r_op;
        w_nxt_addr  = r_addr;
        w_nxt_imm   = r_imm;
        w_nxt_ea    = r_ea;
        w_nxt_opnd  = r_opnd;
        w_nxt_tmp   = r_tmp;
        w_nxt_skip  = r_skip;
        w_nxt_ac    = r_ac;
        w_nxt_e     = r_e;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_nxt_op   = w_start_op;
                    w_nxt_addr = i_addr;
                    w_nxt_imm  = i_imm;
                    w_nxt_skip = 1'b0;
                    if (is_mem_op(w_start_op)) begin
                        if (i_is_ind) begin
                            w_nxt_state = ST_IND_RD;
                        end else begin
                            w_nxt_ea    = i_addr;
                            w_nxt_state = mem_first_state(w_start_op);
                        end
                    end else if (w_start_op == OP_NONE) begin
                        w_nxt_state = ST_DONE;
                    end else begin
                        w_nxt_state = ST_REG_EX;
                    end
                end
            end
            ST_IND_RD: begin
                if (w_acc) begin
                    w_nxt_ea    = i_mem_rdata[AWIDTH-1:0];
                    w_nxt_state = mem_first_state(r_op);
                end
            end
            ST_OP_RD: begin
                if (w_acc) begin
                    w_nxt_opnd  = i_mem_rdata;
                    w_nxt_state = ST_REG_EX;
                end
            end
            // Shared ALU cycle for reg-ref ops and for operands captured in OP_RD
            ST_REG_EX: begin
                if (r_op == OP_ISZ) begin
                    w_nxt_tmp   = w_alu_ac;
                    w_nxt_skip  = w_alu_zero;
                    w_nxt_state = ST_OP_WR;
                end else begin
                    w_nxt_ac    = w_alu_ac;
                    w_nxt_e     = w_alu_e;
                    w_nxt_state = ST_DONE;
                end
            end
            ST_OP_WR: begin
                if (w_acc) begin
                    w_nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // Registered outputs are derived from the next state so they line up with it
        w_nxt_req     = (w_nxt_state == ST_IND_RD) || (w_nxt_state == ST_OP_RD) ||
                        (w_nxt_state == ST_OP_WR);
        w_nxt_we      = (w_nxt_state == ST_OP_WR);
        w_nxt_maddr   = '0;
        w_nxt_wdata   = '0;
        if (w_nxt_req) begin
            w_nxt_maddr = (w_nxt_state == ST_IND_RD) ? w_nxt_addr : w_nxt_ea;
        end
        if (w_nxt_we) begin
            w_nxt_wdata = (w_nxt_op == OP_ISZ) ? w_nxt_tmp : w_nxt_ac;
        end
        w_nxt_ex_done = (w_nxt_state == ST_DONE);
        w_nxt_pc_load = (w_nxt_state == ST_DONE) && (w_nxt_op == OP_BRANCH);
        w_nxt_pc_skip = (w_nxt_state == ST_DONE) && w_nxt_skip;
        w_nxt_busy    = (w_nxt_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NONE;
            r_exec_d    <= 1'b0;
            r_addr      <= '0;
            r_imm       <= '0;
            r_ea        <= '0;
            r_opnd      <= '0;
            r_tmp       <= '0;
            r_skip      <= 1'b0;
            r_ac        <= '0;
            r_e         <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pc_load   <= 1'b0;
            r_pc_skip   <= 1'b0;
            r_busy      <= 1'b0;
            r_ex_done   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_op        <= w_nxt_op;
            r_exec_d    <= i_execute;
            r_addr      <= w_nxt_addr;
            r_imm       <= w_nxt_imm;
            r_ea        <= w_nxt_ea;
            r_opnd      <= w_nxt_opnd;
            r_tmp       <= w_nxt_tmp;
            r_skip      <= w_nxt_skip;
            r_ac        <= w_nxt_ac;
            r_e         <= w_nxt_e;
            r_mem_req   <= w_nxt_req;
            r_mem_we    <= w_nxt_we;
            r_mem_addr  <= w_nxt_maddr;
            r_mem_wdata <= w_nxt_wdata;
            r_pc_load   <= w_nxt_pc_load;
            r_pc_skip   <= w_nxt_pc_skip;
            r_busy      <= w_nxt_busy;
            r_ex_done   <= w_nxt_ex_done;
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_ac        = r_ac;
    assign o_e         = r_e;
    assign o_pc_load   = r_pc_load;
    assign o_pc_value  = r_ea;
    assign o_pc_skip   = r_pc_skip;
    assign o_busy      = r_busy;
    assign o_ex_done   = r_ex_done;

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed bench for cpu_exec_unit: instruction vector table plus wait-state and reset sequences.
module tb_cpu_exec_unit;

    localparam logic [11:0] S_ADD    = 12'h800;
    localparam logic [11:0] S_LOAD   = 12'h400;
    localparam logic [11:0] S_STORE  = 12'h200;
    localparam logic [11:0] S_BRANCH = 12'h100;
    localparam logic [11:0] S_ISZ    = 12'h080;
    localparam logic [11:0] S_CLR_AC = 12'h040;
    localparam logic [11:0] S_CLR_E  = 12'h020;
    localparam logic [11:0] S_COMP   = 12'h010;
    localparam logic [11:0] S_LDAC   = 12'h008;
    localparam logic [11:0] S_CIR_R  = 12'h004;
    localparam logic [11:0] S_CIR_L  = 12'h002;
    localparam logic [11:0] S_INC    = 12'h001;
    localparam int NV = 25;

    typedef struct {
        logic [11:0] strb;
        logic        ind;
        logic [11:0] addr;
        logic [7:0]  imm;
        logic [15:0] ac;
        logic        e;
        int          lat;
        logic        ld;
        logic        sk;
        logic [11:0] pcv;
    } vec_t;

    logic        clk, reset_n;
    logic        execute, is_ind;
    logic [11:0] addr_in;
    logic [7:0]  imm_in;
    logic        s_add, s_load, s_store, s_branch, s_isz;
    logic        s_clr_ac, s_clr_e, s_comp, s_ldac, s_cir_r, s_cir_l, s_inc;
    logic        o_mem_req, o_mem_we;
    logic [11:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] o_ac;
    logic        o_e, o_pc_load, o_pc_skip, o_busy, o_ex_done;
    logic [11:0] o_pc_value;

    logic [15:0] mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [15:0] pre_data;
    int          req_cnt;
    int          ack_delay;
    int          n_cmp, n_fail;
    vec_t        vecs [NV];

    cpu_exec_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_execute   (execute),
        .i_is_ind    (is_ind),
        .i_addr      (addr_in),
        .i_imm       (imm_in),
        .i_add       (s_add),
        .i_load      (s_load),
        .i_store     (s_store),
        .i_branch    (s_branch),
        .i_isz       (s_isz),
        .i_clr_ac    (s_clr_ac),
        .i_clr_e     (s_clr_e),
        .i_comp_ac   (s_comp),
        .i_load_ac   (s_ldac),
        .i_cir_r     (s_cir_r),
        .i_cir_l     (s_cir_l),
        .i_inc_ac    (s_inc),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_ac        (o_ac),
        .o_e         (o_e),
        .o_pc_load   (o_pc_load),
        .o_pc_value  (o_pc_value),
        .o_pc_skip   (o_pc_skip),
        .o_busy      (o_busy),
        .o_ex_done   (o_ex_done)
    );

    always #5 clk = ~clk;

    // Memory model: ack after ack_delay request cycles, reads combinational
    assign mem_ack   = o_mem_req && (req_cnt >= ack_delay);
    assign mem_rdata = mem[o_mem_addr];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (o_mem_req && o_mem_we && mem_ack) mem[o_mem_addr] <= o_mem_wdata;
        req_cnt <= (o_mem_req && !mem_ack) ? req_cnt + 1 : 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic drive_strb(input logic [11:0] s);
        s_add = s[11]; s_load = s[10]; s_store = s[9]; s_branch = s[8]; s_isz = s[7];
        s_clr_ac = s[6]; s_clr_e = s[5]; s_comp = s[4]; s_ldac = s[3];
        s_cir_r = s[2]; s_cir_l = s[1]; s_inc = s[0];
    endtask

    task automatic run_instr(input logic [11:0] s, input logic ind, input logic [11:0] a,
                             input logic [7:0] im, output int lat, output logic ld,
                             output logic sk, output logic [11:0] pcv, output logic [1:0] after);
        logic done;
        drive_strb(s); is_ind = ind; addr_in = a; imm_in = im; execute = 1'b1;
        lat = 0; done = 1'b0; ld = 1'b0; sk = 1'b0; pcv = '0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_ex_done) begin
                done = 1'b1; ld = o_pc_load; sk = o_pc_skip; pcv = o_pc_value;
            end
        end
        if (!done) lat = -1;
        execute = 1'b0; drive_strb(12'h000);
        @(posedge clk); #1;
        after = {o_ex_done, o_busy};
    endtask

    initial begin
        int          lat;
        logic        ld, sk;
        logic [11:0] pcv;
        logic [1:0]  after;

        clk = 1'b0; reset_n = 1'b0; execute = 1'b0; is_ind = 1'b0;
        addr_in = '0; imm_in = '0; drive_strb(12'h000);
        pre_we = 1'b0; pre_addr = '0; pre_data = '0; req_cnt = 0; ack_delay = 0;
        n_cmp = 0; n_fail = 0;

        vecs[0]  = '{S_LOAD,           1'b0, 12'h010, 8'h00, 16'h1234, 1'b0, 3, 1'b0, 1'b0, 12'h000};
        vecs[1]  = '{S_CLR_AC,         1'b0, 12'h000, 8'h00, 16'h0000, 1'b0, 2, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{S_COMP,           1'b0, 12'h000, 8'h00, 16'hFFFF, 1'b0, 2, 1'b0, 1'b0, 12'h000};
        vecs[3]  = '{S_ADD,            1'b0, 12'h020, 8'h00, 16'h0001, 1'b1, 3, 1'b0, 1'b0, 12'h000};
        vecs[4]  = '{S_CLR_E,          1'b0, 12'h000, 8'h00, 16'h0001, 1'b0, 2, 1'b0, 1'b0, 12'h000};
        vecs[5]  = '{S_LOAD,           1'b0, 12'h070, 8'h00, 16'h8001, 1'b0, 3, 1'b0, 1'b0, 12'h000};
        vecs[6]  = '{S_CIR_R,          1'b0, 12'h000, 8'h00, 16'h4000, 1'b1, 2, 1'b0, 1'b0, 12'h000};
        vecs[7]  = '{S_CIR_L,          1'b0, 12'h000, 8'h00, 16'h8001, 1'b0, 2, 1'b0, 1'b0, 12'h000};
        vecs[8]  = '{S_LDAC,           1'b0, 12'h000, 8'h5A, 16'h005A, 1'b0, 2, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{S_INC,            1'b0, 12'h000, 8'h00, 16'h005B, 1'b0, 2, 1'b0, 1'b0, 12'h000};
        vecs[10] = '{S_LOAD,           1'b0, 12'h080, 8'h00, 16'hBEEF, 1'b0, 3, 1'b0, 1'b0, 12'h000};
        vecs[11] = '{S_STORE,          1'b1, 12'h030, 8'h00, 16'hBEEF, 1'b0, 3, 1'b0, 1'b0, 12'h000};
        vecs[12] = '{S_ISZ,            1'b0, 12'h040, 8'h00, 16'hBEEF, 1'b0, 4, 1'b0, 1'b1, 12'h000};
        vecs[13] = '{S_ISZ,            1'b0, 12'h050, 8'h00, 16'hBEEF, 1'b0, 4, 1'b0, 1'b0, 12'h000};
        vecs[14] = '{S_BRANCH,         1'b0, 12'h123, 8'h00, 16'hBEEF, 1'b0, 1, 1'b1, 1'b0, 12'h123};
        vecs[15] = '{S_BRANCH,         1'b1, 12'h060, 8'h00, 16'hBEEF, 1'b0, 2, 1'b1, 1'b0, 12'hABC};
        vecs[16] = '{S_ADD,            1'b1, 12'h090, 8'h00, 16'hD123, 1'b0, 4, 1'b0, 1'b0, 12'h000};
        vecs[17] = '{12'h000,          1'b0, 12'h000, 8'h00, 16'hD123, 1'b0, 1, 1'b0, 1'b0, 12'h000};
        vecs[18] = '{S_ADD | S_LOAD,   1'b0, 12'h020, 8'h00, 16'hD125, 1'b0, 3, 1'b0, 1'b0, 12'h000};
        vecs[19] = '{S_CLR_AC | S_INC, 1'b0, 12'h000, 8'h00, 16'h0000, 1'b0, 2, 1'b0, 1'b0, 12'h000};
        vecs[20] = '{S_LOAD | S_CLR_AC,1'b0, 12'h010, 8'h00, 16'h1234, 1'b0, 3, 1'b0, 1'b0, 12'h000};
        vecs[21] = '{S_LOAD,           1'b0, 12'h0A0, 8'h00, 16'hFFFF, 1'b0, 3, 1'b0, 1'b0, 12'h000};
        vecs[22] = '{S_ADD,            1'b0, 12'h0A0, 8'h00, 16'hFFFE, 1'b1, 3, 1'b0, 1'b0, 12'h000};
        vecs[23] = '{S_INC,            1'b0, 12'h000, 8'h00, 16'hFFFF, 1'b1, 2, 1'b0, 1'b0, 12'h000};
        vecs[24] = '{S_INC,            1'b0, 12'h000, 8'h00, 16'h0000, 1'b1, 2, 1'b0, 1'b0, 12'h000};

        @(posedge clk); #1;
        poke(12'h010, 16'h1234); poke(12'h020, 16'h0002); poke(12'h030, 16'h0456);
        poke(12'h040, 16'hFFFF); poke(12'h050, 16'h0007); poke(12'h060, 16'hFABC);
        poke(12'h070, 16'h8001); poke(12'h080, 16'hBEEF); poke(12'h090, 16'h0010);
        poke(12'h0A0, 16'hFFFF); poke(12'h0B0, 16'h7777);

        check("rst_ac", 32'(o_ac), 32'h0);
        check("rst_flags", {27'h0, o_e, o_mem_req, o_busy, o_ex_done, o_pc_load}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst", {26'h0, o_busy, o_mem_req, o_ex_done, o_pc_skip, o_pc_load, o_e}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            run_instr(vecs[i].strb, vecs[i].ind, vecs[i].addr, vecs[i].imm, lat, ld, sk, pcv, after);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_ac", i), 32'(o_ac), 32'(vecs[i].ac));
            check($sformatf("v%0d_e", i), 32'(o_e), 32'(vecs[i].e));
            check($sformatf("v%0d_pcload", i), 32'(ld), 32'(vecs[i].ld));
            check($sformatf("v%0d_pcskip", i), 32'(sk), 32'(vecs[i].sk));
            check($sformatf("v%0d_after", i), 32'(after), 32'h0);
            if (vecs[i].ld) check($sformatf("v%0d_pcval", i), 32'(pcv), 32'(vecs[i].pcv));
        end
        check("mem_ind_store", 32'(mem[12'h456]), 32'hBEEF);
        check("mem_isz_wrap", 32'(mem[12'h040]), 32'h0000);
        check("mem_isz_inc", 32'(mem[12'h050]), 32'h0008);

        // Delayed ack: request held stable for five wait cycles
        ack_delay = 5;
        drive_strb(S_LOAD); is_ind = 1'b0; addr_in = 12'h0B0; execute = 1'b1;
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            lat++;
            check($sformatf("wait_hold%0d", k), {17'h0, o_mem_req, o_mem_we, mem_ack, o_mem_addr},
                  {17'h0, 1'b1, 1'b0, 1'b0, 12'h0B0});
        end
        @(posedge clk); #1;
        lat++;
        check("wait_ack", {31'h0, mem_ack}, 32'h1);
        while (!o_ex_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("wait_lat", 32'(lat), 32'd8);
        check("wait_ac", 32'(o_ac), 32'h7777);
        execute = 1'b0; drive_strb(12'h000);
        @(posedge clk); #1;

        // Reset in the middle of a stalled operand read
        drive_strb(S_LOAD); addr_in = 12'h010; execute = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_req", {31'h0, o_mem_req}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_req", {31'h0, o_mem_req}, 32'h0);
        check("rst_mid_busy", {31'h0, o_busy}, 32'h0);
        check("rst_mid_ac", 32'(o_ac), 32'h0);
        check("rst_mid_e", {31'h0, o_e}, 32'h0);
        execute = 1'b0; drive_strb(12'h000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ack_delay = 0;
        @(posedge clk); #1;
        run_instr(S_LDAC, 1'b0, 12'h000, 8'h11, lat, ld, sk, pcv, after);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_ac", 32'(o_ac), 32'h0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
